serial_add_ctrl: RTL and testbench

Bit-serial adder controller. It sequences a single 1-bit full adder over WIDTH cycles to add two WIDTH-bit operands with carry-in. It sits between a requester issuing start/operands and the shared 1-bit adder cell, trading latency for area. A start/busy/done handshake governs operand capture and result delivery.

---
 rtl/serial_add_pkg.sv | 17 +
 rtl/serial_add_ctrl_if.sv | 34 +++
 rtl/serial_add_ctrl_fa.sv | 18 +
 rtl/serial_add_ctrl.sv | 142 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// ----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder controller.
// - DEFAULT_WIDTH : default operand/result width.
// - state_t       : 2-bit FSM state encoding (IDLE / RUN / DONE).
// ----------------------------------------------------------------------------
package serial_add_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef logic [1:0] state_t;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// ----------------------------------------------------------------------------
// serial_add_ctrl_if
// Request/result bundle between a requester and serial_add_ctrl.
// - start, a, b, cin : request and operands (requester -> controller)
// - busy, done       : handshake status     (controller -> requester)
// - sum, cout        : registered result    (controller -> requester)
// master = requester side, slave = controller side.
// ----------------------------------------------------------------------------
interface serial_add_ctrl_if
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );

endinterface

// File: rtl/serial_add_ctrl_fa.sv
// ----------------------------------------------------------------------------
// fa
// One-bit full adder cell shared by the serial adder datapath.
// - a, b, cin : addend bits and carry-in
// - sum, cout : sum bit and carry-out
// ----------------------------------------------------------------------------
module fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder controller: adds two WIDTH-bit operands plus carry-in by
// stepping a single full adder cell LSB-first over WIDTH cycles.
// Ports:
// - clk  : rising-edge clock
// - rst  : synchronous active-high reset (aborts any operation in flight)
// - bus  : serial_add_ctrl_if slave modport
//          start/a/b/cin sampled on the accepting edge (busy=0),
//          busy high during RUN, done pulses one cycle with a new sum/cout,
//          sum/cout held until the next completion.
// ----------------------------------------------------------------------------
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   serial_add_ctrl_if.slave    bus
);

   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state_reg,  state_next;
   logic [CNT_W-1:0]   cnt_reg,    cnt_next;
   logic [WIDTH-1:0]   a_sr_reg,   a_sr_next;
   logic [WIDTH-1:0]   b_sr_reg,   b_sr_next;
   logic [WIDTH-1:0]   s_sr_reg,   s_sr_next;
   logic               carry_reg,  carry_next;
   logic [WIDTH-1:0]   sum_reg,    sum_next;
   logic               cout_reg,   cout_next;

   logic               fa_sum;
   logic               fa_cout;

   // Shifted views of the operand and sum registers; the sum register takes
   // the current adder bit at its MSB so that after WIDTH steps the first
   // (LSB) bit has walked down to bit 0.
   logic [WIDTH-1:0]   a_shift;
   logic [WIDTH-1:0]   b_shift;
   logic [WIDTH-1:0]   s_shift;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
         assign a_shift[gi] = a_sr_reg[gi + 1];
         assign b_shift[gi] = b_sr_reg[gi + 1];
         assign s_shift[gi] = s_sr_reg[gi + 1];
      end
   endgenerate

   assign a_shift[WIDTH-1] = 1'b0;
   assign b_shift[WIDTH-1] = 1'b0;
   assign s_shift[WIDTH-1] = fa_sum;

   fa u_fa (
      .a    (a_sr_reg[0]),
      .b    (b_sr_reg[0]),
      .cin  (carry_reg),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      a_sr_next  = a_sr_reg;
      b_sr_next  = b_sr_reg;
      s_sr_next  = s_sr_reg;
      carry_next = carry_reg;
      sum_next   = sum_reg;
      cout_next  = cout_reg;

      case (state_reg)
         IDLE, DONE: begin
            // Both idle states accept a request; accepting in DONE gives
            // back-to-back operation without an IDLE bubble.
            if (bus.start) begin
               a_sr_next  = bus.a;
               b_sr_next  = bus.b;
               carry_next = bus.cin;
               cnt_next   = '0;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end

         RUN: begin
            a_sr_next  = a_shift;
            b_sr_next  = b_shift;
            s_sr_next  = s_shift;
            carry_next = fa_cout;
            if (cnt_reg == CNT_LAST) begin
               // Final bit: publish the result on this same edge.
               sum_next   = s_shift;
               cout_next  = fa_cout;
               cnt_next   = '0;
               state_next = DONE;
            end else begin
               cnt_next   = cnt_reg + 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         a_sr_reg  <= '0;
         b_sr_reg  <= '0;
         s_sr_reg  <= '0;
         carry_reg <= 1'b0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         a_sr_reg  <= a_sr_next;
         b_sr_reg  <= b_sr_next;
         s_sr_reg  <= s_sr_next;
         carry_reg <= carry_next;
         sum_reg   <= sum_next;
         cout_reg  <= cout_next;
      end
   end

   // Status is a direct decode of the state register, so busy and done are
   // mutually exclusive and carry no path from the inputs.
   assign bus.busy = (state_reg == RUN);
   assign bus.done = (state_reg == DONE);
   assign bus.sum  = sum_reg;
   assign bus.cout = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Directed and randomised checks of serial_add_ctrl with WIDTH=8.
// Inputs are driven on the falling edge or just after the rising edge;
// outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   serial_add_ctrl_if #(.WIDTH(W)) bus ();

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Present a request for exactly one rising edge (E0); returns just after E0.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      @(negedge clk);
      bus.a     = a;
      bus.b     = b;
      bus.cin   = cin;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Observe falling edges until done is seen (bounded); k = -1 on timeout.
   task automatic wait_done(output int k, output int busy_cycles, output int overlap);
      bit seen;
      seen = 1'b0;
      k = 0;
      busy_cycles = 0;
      overlap = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         k++;
         if (bus.busy) busy_cycles++;
         if (bus.busy && bus.done) overlap++;
         if (bus.done) seen = 1'b1;
      end
      if (!seen) k = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({bus.busy, bus.done, bus.cout, bus.sum} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
         tests_failed++;
         $display("FAIL reset: busy=%b done=%b cout=%b sum=%h, need 0 0 0 00",
                  bus.busy, bus.done, bus.cout, bus.sum);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      $display("[TB] reset checked");
   endtask

   task automatic test_basic();
      int k, bc, ov;
      start_op(8'h5A, 8'h3C, 1'b0);
      wait_done(k, bc, ov);
      tests_run++;
      if (k !== W + 1 || bc !== W || ov !== 0) begin
         tests_failed++;
         $display("FAIL basic_timing: done_at=%0d busy_cycles=%0d overlap=%0d, need %0d %0d 0",
                  k, bc, ov, W + 1, W);
      end
      tests_run++;
      if ({bus.cout, bus.sum} !== {1'b0, 8'h96}) begin
         tests_failed++;
         $display("FAIL basic_result: cout=%b sum=%h, need 0 96", bus.cout, bus.sum);
      end
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b0 || bus.sum !== 8'h96) begin
         tests_failed++;
         $display("FAIL basic_pulse: done=%b sum=%h, need 0 96", bus.done, bus.sum);
      end
      $display("[TB] 5A+3C+0 -> cout=%b sum=%h done_at=%0d", bus.cout, bus.sum, k);
   endtask

   task automatic test_overflow();
      int k, bc, ov;
      start_op(8'hFF, 8'h01, 1'b0);
      wait_done(k, bc, ov);
      tests_run++;
      if (k !== W + 1 || {bus.cout, bus.sum} !== {1'b1, 8'h00}) begin
         tests_failed++;
         $display("FAIL ovf_ff_01: done_at=%0d cout=%b sum=%h, need %0d 1 00",
                  k, bus.cout, bus.sum, W + 1);
      end
      $display("[TB] FF+01+0 -> cout=%b sum=%h", bus.cout, bus.sum);
      start_op(8'hFF, 8'hFF, 1'b1);
      wait_done(k, bc, ov);
      tests_run++;
      if (k !== W + 1 || {bus.cout, bus.sum} !== {1'b1, 8'hFF}) begin
         tests_failed++;
         $display("FAIL ovf_ff_ff_1: done_at=%0d cout=%b sum=%h, need %0d 1 ff",
                  k, bus.cout, bus.sum, W + 1);
      end
      $display("[TB] FF+FF+1 -> cout=%b sum=%h", bus.cout, bus.sum);
   endtask

   task automatic test_ignore_start();
      int k, bc, ov, extra;
      start_op(8'h12, 8'h34, 1'b1);
      repeat (2) @(negedge clk);
      bus.a     = 8'h01;
      bus.b     = 8'h01;
      bus.cin   = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(k, bc, ov);
      tests_run++;
      if (k + 3 !== W + 1 || {bus.cout, bus.sum} !== {1'b0, 8'h47}) begin
         tests_failed++;
         $display("FAIL ignore_start: done_at=%0d cout=%b sum=%h, need %0d 0 47",
                  k + 3, bus.cout, bus.sum, W + 1);
      end
      extra = 0;
      repeat (15) begin
         @(negedge clk);
         if (bus.done || bus.busy) extra++;
      end
      tests_run++;
      if (extra !== 0) begin
         tests_failed++;
         $display("FAIL ignore_start_extra: extra busy/done cycles=%0d, need 0", extra);
      end
      $display("[TB] 12+34+1 with mid-run start -> cout=%b sum=%h", bus.cout, bus.sum);
   endtask

   task automatic test_rst_mid_run();
      int late;
      start_op(8'hAA, 8'h55, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({bus.busy, bus.done, bus.cout, bus.sum} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
         tests_failed++;
         $display("FAIL rst_mid_run: busy=%b done=%b cout=%b sum=%h, need 0 0 0 00",
                  bus.busy, bus.done, bus.cout, bus.sum);
      end
      late = 0;
      repeat (15) begin
         @(negedge clk);
         if (bus.done || bus.busy) late++;
      end
      tests_run++;
      if (late !== 0) begin
         tests_failed++;
         $display("FAIL rst_no_done: late busy/done cycles=%0d, need 0", late);
      end
      $display("[TB] reset during RUN -> aborted, sum=%h", bus.sum);
   endtask

   task automatic test_back_to_back();
      int k, bc, ov, held_bad;
      bit seen;
      start_op(8'h5A, 8'h3C, 1'b0);
      wait_done(k, bc, ov);
      tests_run++;
      if (k !== W + 1 || bus.sum !== 8'h96) begin
         tests_failed++;
         $display("FAIL b2b_first: done_at=%0d sum=%h, need %0d 96", k, bus.sum, W + 1);
      end
      // Still inside the DONE cycle: request the next operation now.
      bus.a     = 8'h10;
      bus.b     = 8'h20;
      bus.cin   = 1'b0;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      seen = 1'b0;
      held_bad = 0;
      k = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         k++;
         if (bus.done) seen = 1'b1;
         else if ({bus.cout, bus.sum} !== {1'b0, 8'h96}) held_bad++;
      end
      tests_run++;
      if (!seen || k !== W + 1) begin
         tests_failed++;
         $display("FAIL b2b_gap: second done %0d cycles after first (seen=%b), need %0d",
                  k, seen, W + 1);
      end
      tests_run++;
      if (held_bad !== 0 || {bus.cout, bus.sum} !== {1'b0, 8'h30}) begin
         tests_failed++;
         $display("FAIL b2b_result: held_bad=%0d cout=%b sum=%h, need 0 0 30",
                  held_bad, bus.cout, bus.sum);
      end
      $display("[TB] back-to-back 10+20+0 -> cout=%b sum=%h gap=%0d", bus.cout, bus.sum, k);
   endtask

   task automatic test_random();
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [W:0]   expv, prev;
      int           bad_res, bad_stab, bad_time, k;
      bit           seen;
      bad_res = 0;
      bad_stab = 0;
      bad_time = 0;
      for (int n = 0; n < 1000; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         expv = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         prev = {bus.cout, bus.sum};
         start_op(ra, rb, rc);
         // Scramble inputs after acceptance; they must not matter.
         bus.a = ~ra;
         bus.b = ~rb;
         bus.cin = ~rc;
         seen = 1'b0;
         k = 0;
         for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            k++;
            if (bus.done) seen = 1'b1;
            else if ({bus.cout, bus.sum} !== prev) bad_stab++;
         end
         if (!seen || k !== W + 1) bad_time++;
         if ({bus.cout, bus.sum} !== expv) begin
            bad_res++;
            if (bad_res <= 5)
               $display("FAIL rand_op: %h+%h+%b got cout=%b sum=%h, need %h",
                        ra, rb, rc, bus.cout, bus.sum, expv);
         end
      end
      tests_run++;
      if (bad_res !== 0) begin
         tests_failed++;
         $display("FAIL rand_result: wrong results=%0d, need 0", bad_res);
      end
      tests_run++;
      if (bad_stab !== 0) begin
         tests_failed++;
         $display("FAIL rand_stable: sum/cout changes during RUN=%0d, need 0", bad_stab);
      end
      tests_run++;
      if (bad_time !== 0) begin
         tests_failed++;
         $display("FAIL rand_latency: latency errors=%0d, need 0", bad_time);
      end
      $display("[TB] random sweep of 1000 operations done, %0d bad results", bad_res);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      test_reset();
      test_basic();
      test_overflow();
      test_ignore_start();
      test_rst_mid_run();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
